// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU result capture, accumulator/flag commit and branch condition decode
// Two-phase capture/commit FSM with busy/done handshake toward the control sequencer.
module alu_result_stage #(
  parameter int WIDTH = 16,
  parameter int NCOND = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH:0]   res_in,
  input  logic [3:0]       op_in,
  input  logic             cap_req,
  input  logic             acc_oe,
  input  logic             flags_clr,
  input  logic [2:0]       cond_sel,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] bus_out,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done,
  output logic             cond_true
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH:0]   res_q;
  logic [3:0]       op_q;
  logic [3:0]       flags_calc;
  logic [NCOND-1:0] cond_vec;
  logic             arith;
  logic             capture;

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cap_req) begin
          capture = 1'b1;
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        busy    = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Opcodes 0-3 are arithmetic; logic and undefined opcodes force C and V low.
  always_comb begin
    arith         = (op_q < 4'd4);
    flags_calc    = 4'b0000;
    flags_calc[3] = (res_q[WIDTH-1:0] == '0);
    flags_calc[2] = res_q[WIDTH-1];
    flags_calc[1] = arith & res_q[WIDTH];
    flags_calc[0] = arith & (res_q[WIDTH] ^ res_q[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      op_q    <= '0;
      acc_out <= '0;
      flags   <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        res_q <= res_in;
        op_q  <= op_in;
      end
      // A commit takes priority over a coincident flag clear.
      if (state_q == ST_COMMIT) begin
        acc_out <= res_q[WIDTH-1:0];
        flags   <= flags_calc;
      end else if (flags_clr) begin
        flags <= '0;
      end
    end
  end

  always_comb begin
    cond_vec    = '0;
    cond_vec[0] = 1'b1;
    cond_vec[1] = flags[3];
    cond_vec[2] = ~flags[3];
    cond_vec[3] = flags[1];
    cond_vec[4] = flags[2];
    cond_vec[5] = ~flags[2] & ~flags[3];
    cond_vec[6] = flags[0];
    cond_vec[7] = 1'b0;
  end

  assign cond_true = cond_vec[cond_sel];
  assign bus_out   = acc_oe ? acc_out : '0;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - scoreboard bench for alu_result_stage
// Driver pushes expected commits; a negedge monitor pops them on done.
module tb_alu_result_stage;

  logic        clk;
  logic        rst;
  logic [16:0] res_in;
  logic [3:0]  op_in;
  logic        cap_req;
  logic        acc_oe;
  logic        flags_clr;
  logic [2:0]  cond_sel;
  logic [15:0] acc_out;
  logic [15:0] bus_out;
  logic [3:0]  flags;
  logic        busy;
  logic        done;
  logic        cond_true;

  alu_result_stage #(.WIDTH(16), .NCOND(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .res_in    (res_in),
    .op_in     (op_in),
    .cap_req   (cap_req),
    .acc_oe    (acc_oe),
    .flags_clr (flags_clr),
    .cond_sel  (cond_sel),
    .acc_out   (acc_out),
    .bus_out   (bus_out),
    .flags     (flags),
    .busy      (busy),
    .done      (done),
    .cond_true (cond_true)
  );

  typedef struct {
    logic [15:0] acc;
    logic [3:0]  flg;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mdl_acc;
  int          errors;
  int          checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Signed interpretation of the 17-bit result decides carry (negative) and overflow (out of 16-bit range).
  function automatic exp_t model(input logic [16:0] r, input logic [3:0] op);
    exp_t e;
    int   s;
    logic z, n, c, v;
    s     = r[16] ? int'(r) - 131072 : int'(r);
    e.acc = r[15:0];
    z     = (int'(e.acc) == 0);
    n     = (int'(e.acc) > 32767);
    c     = (op <= 4'd3) && (s < 0);
    v     = (op <= 4'd3) && ((s > 32767) || (s < -32768));
    e.flg = {z, n, c, v};
    return e;
  endfunction

  function automatic logic cond_of(input logic [3:0] f, input logic [2:0] sel);
    case (sel)
      3'd0:    return 1'b1;
      3'd1:    return f[3];
      3'd2:    return !f[3];
      3'd3:    return f[1];
      3'd4:    return f[2];
      3'd5:    return !f[2] && !f[3];
      3'd6:    return f[0];
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic capture(input logic [16:0] r, input logic [3:0] op, input logic [2:0] cs,
                         input logic oe, input logic clr);
    sb.push_back(model(r, op));
    res_in  = r;
    op_in   = op;
    cond_sel = cs;
    acc_oe  = oe;
    cap_req = 1'b1;
    step();
    cap_req   = 1'b0;
    flags_clr = clr;
    res_in    = 17'($urandom);
    op_in     = 4'($urandom);
    chk("busy_commit", 32'(busy), 32'd1);
    chk("done_commit", 32'(done), 32'd0);
    step();
    flags_clr = 1'b0;
    chk("busy_done", 32'(busy), 32'd1);
    chk("done_pulse", 32'(done), 32'd1);
    step();
    chk("busy_idle", 32'(busy), 32'd0);
    chk("done_idle", 32'(done), 32'd0);
  endtask

  initial begin : monitor
    exp_t e;
    mdl_acc = 16'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mdl_acc = 16'h0;
      end else begin
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
          end else begin
            e = sb.pop_front();
            mdl_acc = e.acc;
            chk("acc_commit", 32'(acc_out), 32'(e.acc));
            chk("flags_commit", 32'(flags), 32'(e.flg));
            chk("cond_commit", 32'(cond_true), 32'(cond_of(e.flg, cond_sel)));
          end
        end
        chk("acc_track", 32'(acc_out), 32'(mdl_acc));
        chk("bus_out", 32'(bus_out), acc_oe ? 32'(mdl_acc) : 32'd0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    res_in    = 17'h0;
    op_in     = 4'h0;
    cap_req   = 1'b0;
    acc_oe    = 1'b1;
    flags_clr = 1'b0;
    cond_sel  = 3'd0;
    step();
    chk("rst_acc", 32'(acc_out), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bus", 32'(bus_out), 32'd0);
    step();
    rst = 1'b0;
    step();

    // ADD overflow
    capture(17'h08000, 4'd0, 3'd6, 1'b1, 1'b0);
    chk("add_acc", 32'(acc_out), 32'h8000);
    chk("add_flags", 32'(flags), 32'b0101);

    // Reset one cycle after the capture request aborts it
    res_in  = 17'h00005;
    op_in   = 4'd0;
    cap_req = 1'b1;
    step();
    cap_req = 1'b0;
    rst     = 1'b1;
    #1;
    chk("midrst_acc", 32'(acc_out), 32'd0);
    chk("midrst_flags", 32'(flags), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_bus", 32'(bus_out), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_nodone", 32'(done), 32'd0);
      chk("midrst_idle", 32'(busy), 32'd0);
    end
    chk("midrst_acc_after", 32'(acc_out), 32'd0);

    // SUB to zero with flags_clr on the commit edge
    capture(17'h00000, 4'd1, 3'd1, 1'b1, 1'b1);
    chk("sub_flags", 32'(flags), 32'b1000);
    cond_sel = 3'd2;
    #1;
    chk("sub_cond_nz", 32'(cond_true), 32'd0);

    // NOT with negative pattern, then flags_clr in IDLE
    capture(17'h0FFFF, 4'd7, 3'd4, 1'b0, 1'b0);
    chk("not_flags", 32'(flags), 32'b0100);
    flags_clr = 1'b1;
    step();
    flags_clr = 1'b0;
    cond_sel  = 3'd4;
    #1;
    chk("clr_flags", 32'(flags), 32'd0);
    chk("clr_acc", 32'(acc_out), 32'hFFFF);
    chk("clr_cond_n", 32'(cond_true), 32'd0);
    acc_oe = 1'b1;
    #1;
    chk("oe_bus", 32'(bus_out), 32'hFFFF);
    acc_oe = 1'b0;
    #1;
    chk("noe_bus", 32'(bus_out), 32'd0);
    step();

    // cap_req held for four cycles: only values 1 and 4 are captured
    sb.push_back(model(17'd1, 4'd0));
    sb.push_back(model(17'd4, 4'd0));
    op_in   = 4'd0;
    res_in  = 17'd1;
    cap_req = 1'b1;
    step();
    res_in = 17'd2;
    chk("b2b_busy1", 32'(busy), 32'd1);
    step();
    res_in = 17'd3;
    step();
    chk("b2b_gap", 32'(busy), 32'd0);
    res_in = 17'd4;
    step();
    cap_req = 1'b0;
    chk("b2b_busy2", 32'(busy), 32'd1);
    step();
    step();
    chk("b2b_acc", 32'(acc_out), 32'd4);

    for (int i = 0; i < 200; i++) begin
      capture(17'($urandom), 4'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 40; i++) begin
      capture({1'($urandom), 16'h0000 | 16'($urandom_range(0, 3)) | {1'($urandom), 15'h0}},
              4'($urandom_range(0, 3)), 3'($urandom), 1'b1, 1'b0);
    end

    repeat (4) step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
